fet_net_bank: RTL and testbench
===============================

Name: fet_net_bank

Overview:
- Clocked, multi-channel, cycle-accurate timing model of open-drain nFET nets. Each of WIDTH channels is an nFET pulling a resistor-pulled-up drain net.
- Rise and fall settling times are derived from the RC parameters and quantised to clock cycles.
- Inertial filtering: input pulses shorter than the settling time never reach the output, and each rejected pulse is counted.
- Used in the system-level simulation model in place of per-gate delay assigns, so whole datapath slices run synchronously with realistic settling latency.

Parameters:
- WIDTH, 8: number of independent channels.
- CLK_NS, 100.0: model clock period in ns.
- FANOUT, 1: gate loads per net.
- DRIVERS, 1: transistors sharing each drain net.
- RPU, 10000: pull-up resistor, ohms.
- VCC, 5.0: pull-up voltage.
- VTH, 2.5: logic-1 threshold voltage.
- CISS_PF, 50.0: FET input capacitance, pF.
- COSS_PF, 8.0: FET output capacitance, pF.
- RDS, 2.5: drain-source on resistance, ohms.
- GLITCH_W, 16: width of the rejected-glitch counter.

Ports:
- clk  input  1  model clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- source  input  WIDTH  per-channel FET source level.
- gate  input  WIDTH  per-channel FET gate level.
- drain  output  WIDTH  modelled net level, registered.
- settled  output  WIDTH  1 = channel has no transition pending, registered.
- glitch_count  output  GLITCH_W  saturating count of aborted transitions, registered.

Behaviour:
- Derived constants (localparams, elaboration time):
  - CAP_PF = CISS_PF*FANOUT + COSS_PF*DRIVERS.
  - RISE_NS = ln(VCC/(VCC-VTH))*RPU*CAP_PF/1000.
  - FALL_NS = ln(VCC/VTH)*RDS*CAP_PF/1000.
  - RISE_CYCLES = max(1, ceil(RISE_NS/CLK_NS)); FALL_CYCLES = max(1, ceil(FALL_NS/CLK_NS)).
  - Defaults give CAP_PF=58, RISE_NS≈402, RISE_CYCLES=5, FALL_NS≈0.1, FALL_CYCLES=1.
  - Counter width = clog2(max(RISE_CYCLES,FALL_CYCLES)+1).
- Per-channel target t[i] = ~gate[i] | source[i], combinational.
- Reset (rst=1 at an edge): drain = all 1 (pulled up), all counters 0, settled = all 1, glitch_count = 0. Reset wins over every other event; reset during a pending transition discards it with no glitch counted.
- Per-channel counter cnt[i], evaluated at each edge with rst=0:
  - t==drain and cnt==0: hold; settled=1.
  - t!=drain: cnt+1. If cnt+1 == N, drain flips to t, cnt=0, settled=1. Otherwise settled=0.
  - N = RISE_CYCLES if t==1, else FALL_CYCLES.
  - Net effect: drain flips on the Nth consecutive edge at which t!=drain. With N=1, drain updates at the first edge that samples the change.
  - t==drain and cnt>0: abort (glitch). cnt=0, settled=1, drain unchanged, one glitch recorded for this channel.
- Direction selection follows the current t; there is no mid-transition reversal case, since t!=drain fixes the direction.
- glitch_count adds the popcount of channels aborting at that edge (0..WIDTH), saturating at 2^GLITCH_W-1. It never wraps.
- Channels are fully independent; simultaneous events on any subset are legal.
- Outputs are stable between edges; no combinational path from inputs to outputs.

Test Plan:
- Reset, defaults: assert rst 2 cycles -> drain=8'hFF, settled=8'hFF, glitch_count=0. Hold gate=0 -> no change.
- Fall: gate[0]=1, source[0]=0 before edge k -> drain[0]=0 after edge k, settled[0] stays 1, other bits unchanged.
- Rise: then gate[0]=0 before edge m -> settled[0]=0 after edges m..m+3; drain[0]=1 and settled[0]=1 after edge m+4.
- Inertial: channel 1 low; gate[1]=0 for 3 edges then 1 -> drain[1] stays 0, glitch_count=1. A 5-edge pulse -> drain[1] rises at the 5th edge, glitch_count still 1.
- Saturation and multi-channel: GLITCH_W=2, abort channels 2,3,4 at the same edge -> glitch_count=3. A further abort -> stays 3.
- Reset mid-rise: rst at 3rd edge of a rise on channel 5 -> drain[5]=1 (reset value), settled=FF, glitch_count=0. Re-driving gate[5]=1 then falls after 1 edge.

Source files
------------

// File: rtl/fet_net_bank.sv
// ---------------------------------------------------------------------------
// fet_net_bank
//
// Clocked, cycle-accurate timing model of WIDTH open-drain nFET nets. Each
// channel is an nFET whose drain net is pulled up through RPU. The RC settling
// times for rising and falling edges are computed from the electrical
// parameters at elaboration time and quantised to whole clock cycles.
//
// Each channel has inertial filtering. The drain flips only after the target
// level has differed from the drain on N consecutive edges. If the target
// returns to the drain level before that, the pending transition is dropped
// and counted as a glitch.
//
// Ports:
//   clk          model clock; all state changes on the rising edge
//   rst          synchronous active-high reset
//   source       per-channel FET source level
//   gate         per-channel FET gate level
//   drain        modelled net level (registered)
//   settled      1 = channel has no transition pending (registered)
//   glitch_count saturating count of aborted transitions (registered)
// ---------------------------------------------------------------------------
module fet_net_bank #(
    parameter int  WIDTH    = 8,
    parameter real CLK_NS   = 100.0,
    parameter int  FANOUT   = 1,
    parameter int  DRIVERS  = 1,
    parameter int  RPU      = 10000,
    parameter real VCC      = 5.0,
    parameter real VTH      = 2.5,
    parameter real CISS_PF  = 50.0,
    parameter real COSS_PF  = 8.0,
    parameter real RDS      = 2.5,
    parameter int  GLITCH_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    source,
    input  logic [WIDTH-1:0]    gate,
    output logic [WIDTH-1:0]    drain,
    output logic [WIDTH-1:0]    settled,
    output logic [GLITCH_W-1:0] glitch_count
);

    // The net load is every gate hanging on the net plus every drain sharing it.
    localparam real CAP_PF  = CISS_PF * FANOUT + COSS_PF * DRIVERS;
    // Rising: the net charges through the pull-up until it crosses VTH.
    localparam real RISE_NS = $ln(VCC / (VCC - VTH)) * RPU * CAP_PF / 1000.0;
    // Falling: the net discharges through the FET on-resistance down to VTH.
    localparam real FALL_NS = $ln(VCC / VTH) * RDS * CAP_PF / 1000.0;

    localparam int RISE_RAW    = $rtoi($ceil(RISE_NS / CLK_NS));
    localparam int FALL_RAW    = $rtoi($ceil(FALL_NS / CLK_NS));
    localparam int RISE_CYCLES = (RISE_RAW < 1) ? 1 : RISE_RAW;
    localparam int FALL_CYCLES = (FALL_RAW < 1) ? 1 : FALL_RAW;
    localparam int MAX_CYCLES  = (RISE_CYCLES > FALL_CYCLES) ? RISE_CYCLES : FALL_CYCLES;
    localparam int CW          = $clog2(MAX_CYCLES + 1);
    localparam int PW          = $clog2(WIDTH + 1);
    localparam int SW          = GLITCH_W + PW;

    localparam logic [CW-1:0] RISE_N = CW'(RISE_CYCLES);
    localparam logic [CW-1:0] FALL_N = CW'(FALL_CYCLES);

    logic [WIDTH-1:0]    drain_reg;
    logic [WIDTH-1:0]    settled_reg;
    logic [GLITCH_W-1:0] glitch_reg;
    logic [CW-1:0]       cnt_reg  [WIDTH];

    logic [WIDTH-1:0]    target;
    logic [WIDTH-1:0]    differ;
    logic [WIDTH-1:0]    done;
    logic [WIDTH-1:0]    abort;
    logic [WIDTH-1:0]    drain_next;
    logic [WIDTH-1:0]    settled_next;
    logic [CW-1:0]       need     [WIDTH];
    logic [CW-1:0]       cnt_inc  [WIDTH];
    logic [CW-1:0]       cnt_next [WIDTH];
    logic [GLITCH_W-1:0] glitch_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            // The net is released (high) unless the FET conducts a low source.
            assign target[gi]  = ~gate[gi] | source[gi];
            assign differ[gi]  = target[gi] ^ drain_reg[gi];
            // The transition direction is set by the target. A pending
            // transition therefore cannot reverse direction midway.
            assign need[gi]    = target[gi] ? RISE_N : FALL_N;
            assign cnt_inc[gi] = cnt_reg[gi] + 1'b1;
            assign done[gi]    = differ[gi] && (cnt_inc[gi] == need[gi]);
            assign abort[gi]   = !differ[gi] && (cnt_reg[gi] != '0);

            assign drain_next[gi]   = done[gi] ? target[gi] : drain_reg[gi];
            assign cnt_next[gi]     = (differ[gi] && !done[gi]) ? cnt_inc[gi] : '0;
            assign settled_next[gi] = !(differ[gi] && !done[gi]);
        end
    endgenerate

    // Several channels can abort on the same edge, so the glitch counter
    // adds the popcount of those aborts. It is computed wide and then clamped,
    // so it saturates instead of wrapping.
    always_comb begin
        logic [PW-1:0] pop;
        logic [SW-1:0] sum;
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(abort[i]);
        end
        sum = {{PW{1'b0}}, glitch_reg} + {{GLITCH_W{1'b0}}, pop};
        if (sum > {{PW{1'b0}}, {GLITCH_W{1'b1}}}) begin
            glitch_next = {GLITCH_W{1'b1}};
        end else begin
            glitch_next = sum[GLITCH_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_reg   <= '1;
            settled_reg <= '1;
            glitch_reg  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            drain_reg   <= drain_next;
            settled_reg <= settled_next;
            glitch_reg  <= glitch_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    assign drain        = drain_reg;
    assign settled      = settled_reg;
    assign glitch_count = glitch_reg;

endmodule

// File: tb/tb_fet_net_bank.sv
// ---------------------------------------------------------------------------
// Testbench for fet_net_bank.
// dut_a uses the default parameters.
// dut_b uses GLITCH_W=2, which exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_fet_net_bank;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [7:0] gate_a, source_a, gate_b, source_b;
    logic [7:0] drain_a, settled_a, drain_b, settled_b;
    logic [15:0] gc_a;
    logic [1:0]  gc_b;

    fet_net_bank dut_a (
        .clk(clk), .rst(rst_a), .source(source_a), .gate(gate_a),
        .drain(drain_a), .settled(settled_a), .glitch_count(gc_a)
    );

    fet_net_bank #(.GLITCH_W(2)) dut_b (
        .clk(clk), .rst(rst_b), .source(source_b), .gate(gate_b),
        .drain(drain_b), .settled(settled_b), .glitch_count(gc_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s #%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Apply inputs just after an edge, then sample 1 ns after the next edge.
    task automatic step_a(input logic r, input logic [7:0] g, input logic [7:0] s);
        rst_a = r; gate_a = g; source_a = s;
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic r, input logic [7:0] g, input logic [7:0] s);
        rst_b = r; gate_b = g; source_b = s;
        @(posedge clk); #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic [7:0]  gate;
        logic [7:0]  source;
        logic [7:0]  exp_drain;
        logic [7:0]  exp_settled;
        logic [15:0] exp_gc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [7:0] g, input logic [7:0] s,
                       input logic [7:0] d, input logic [7:0] st, input logic [15:0] gc);
        vec_t v;
        v.rst = r; v.gate = g; v.source = s;
        v.exp_drain = d; v.exp_settled = st; v.exp_gc = gc;
        vecs.push_back(v);
    endtask

    // ---------------- behavioural reference model ----------------
    // Rule from the timing derivation at default parameters:
    // rise takes 5 edges and fall takes 1.
    // A channel's drain flips once the target has differed from it on that
    // many consecutive edges. A run broken early counts as one glitch.
    localparam int RISE_EDGES = 5;
    localparam int FALL_EDGES = 1;
    int        m_run[8];
    bit        m_drain[8];
    longint    m_gc;

    task automatic model_edge(input logic r, input logic [7:0] g, input logic [7:0] s);
        for (int i = 0; i < 8; i++) begin
            bit t;
            t = !g[i] || s[i];
            if (r) begin
                m_drain[i] = 1'b1;
                m_run[i]   = 0;
            end else if (t != m_drain[i]) begin
                m_run[i]++;
                if (m_run[i] == (t ? RISE_EDGES : FALL_EDGES)) begin
                    m_drain[i] = t;
                    m_run[i]   = 0;
                end
            end else if (m_run[i] > 0) begin
                m_gc++;
                m_run[i] = 0;
            end
        end
        if (r) m_gc = 0;
        if (m_gc > 65535) m_gc = 65535;
    endtask

    function automatic logic [7:0] model_drain();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_drain[i];
        return v;
    endfunction

    function automatic logic [7:0] model_settled();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = (m_run[i] == 0);
        return v;
    endfunction

    initial begin
        rst_a = 1'b1; gate_a = 8'h00; source_a = 8'h00;
        rst_b = 1'b1; gate_b = 8'h00; source_b = 8'h00;

        // Reset, hold, fall, rise, inertial rejection on dut_a.
        add(1, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
        add(1, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
        add(0, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
        add(0, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
        add(0, 8'h04, 8'h04, 8'hFF, 8'hFF, 0);   // conducting but source high: net stays high
        add(0, 8'h01, 8'h00, 8'hFE, 8'hFF, 0);   // fall on ch0 after one edge
        add(0, 8'h01, 8'h00, 8'hFE, 8'hFF, 0);
        add(0, 8'h00, 8'h00, 8'hFE, 8'hFE, 0);   // rise edge m
        add(0, 8'h00, 8'h00, 8'hFE, 8'hFE, 0);
        add(0, 8'h00, 8'h00, 8'hFE, 8'hFE, 0);
        add(0, 8'h00, 8'h00, 8'hFE, 8'hFE, 0);
        add(0, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);   // edge m+4: drain rises
        add(0, 8'h02, 8'h00, 8'hFD, 8'hFF, 0);   // ch1 low
        add(0, 8'h00, 8'h00, 8'hFD, 8'hFD, 0);   // 3-edge release
        add(0, 8'h00, 8'h00, 8'hFD, 8'hFD, 0);
        add(0, 8'h00, 8'h00, 8'hFD, 8'hFD, 0);
        add(0, 8'h02, 8'h00, 8'hFD, 8'hFF, 1);   // abort: glitch
        add(0, 8'h00, 8'h00, 8'hFD, 8'hFD, 1);   // 5-edge release
        add(0, 8'h00, 8'h00, 8'hFD, 8'hFD, 1);
        add(0, 8'h00, 8'h00, 8'hFD, 8'hFD, 1);
        add(0, 8'h00, 8'h00, 8'hFD, 8'hFD, 1);
        add(0, 8'h00, 8'h00, 8'hFF, 8'hFF, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step_a(vecs[i].rst, vecs[i].gate, vecs[i].source);
            check("vec_drain", i, {8'h00, drain_a}, {8'h00, vecs[i].exp_drain});
            check("vec_settled", i, {8'h00, settled_a}, {8'h00, vecs[i].exp_settled});
            check("vec_glitch", i, gc_a, vecs[i].exp_gc);
            $display("[TB] vec %0d rst=%0b gate=%h src=%h -> drain=%h settled=%h gc=%0d",
                     i, vecs[i].rst, vecs[i].gate, vecs[i].source, drain_a, settled_a, gc_a);
        end

        // dut_b: multi-channel abort and saturation at GLITCH_W=2.
        step_b(1, 8'h00, 8'h00);
        step_b(0, 8'h1C, 8'h00);                 // ch2..4 fall
        check("sat_fall", 0, {8'h00, drain_b}, 16'h00E3);
        step_b(0, 8'h00, 8'h00);
        step_b(0, 8'h00, 8'h00);
        check("sat_pend", 0, {8'h00, settled_b}, 16'h00E3);
        step_b(0, 8'h1C, 8'h00);                 // three aborts on one edge
        check("sat_three", 0, {14'h0, gc_b}, 16'd3);
        check("sat_drain", 0, {8'h00, drain_b}, 16'h00E3);
        $display("[TB] sat: triple abort gc=%0d", gc_b);
        step_b(0, 8'h00, 8'h00);
        step_b(0, 8'h1C, 8'h00);                 // further abort
        check("sat_hold", 0, {14'h0, gc_b}, 16'd3);
        $display("[TB] sat: extra abort gc=%0d", gc_b);

        // dut_b: reset in the middle of a rise on ch5.
        step_b(1, 8'h00, 8'h00);
        step_b(0, 8'h20, 8'h00);
        check("rst_fall5", 0, {8'h00, drain_b}, 16'h00DF);
        step_b(0, 8'h00, 8'h00);
        step_b(0, 8'h00, 8'h00);
        check("rst_pend5", 0, {8'h00, settled_b}, 16'h00DF);
        step_b(1, 8'h00, 8'h00);                 // 3rd edge of the rise
        check("rst_drain", 0, {8'h00, drain_b}, 16'h00FF);
        check("rst_settled", 0, {8'h00, settled_b}, 16'h00FF);
        check("rst_gc", 0, {14'h0, gc_b}, 16'd0);
        step_b(0, 8'h20, 8'h00);
        check("refall5", 0, {8'h00, drain_b}, 16'h00DF);
        check("refall_gc", 0, {14'h0, gc_b}, 16'd0);
        $display("[TB] reset mid-rise: drain=%h settled=%h gc=%0d", drain_b, settled_b, gc_b);

        // Randomised run on dut_a against the behavioural model.
        begin
            logic [7:0] g, s;
            logic       r;
            g = 8'h00; s = 8'h00;
            for (int i = 0; i < 8; i++) begin m_run[i] = 0; m_drain[i] = 1'b1; end
            m_gc = 0;
            step_a(1, g, s);
            for (int c = 0; c < 600; c++) begin
                for (int b = 0; b < 8; b++) begin
                    if ($urandom_range(5, 0) == 0) g[b] = ~g[b];
                    if ($urandom_range(7, 0) == 0) s[b] = ~s[b];
                end
                r = ($urandom_range(99, 0) == 0);
                model_edge(r, g, s);
                step_a(r, g, s);
                check("rnd_drain", c, {8'h00, drain_a}, {8'h00, model_drain()});
                check("rnd_settled", c, {8'h00, settled_a}, {8'h00, model_settled()});
                check("rnd_glitch", c, gc_a, m_gc[15:0]);
                $display("[TB] rnd %0d rst=%0b gate=%h src=%h -> drain=%h settled=%h gc=%0d",
                         c, r, g, s, drain_a, settled_a, gc_a);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
